// File: rtl/felica_deframer_if.sv
// Handshake bundle between the Manchester demodulator, the deframer and the capture logic.
// master drives the bit stream; slave is the deframer.
interface felica_deframer_if;
   logic       bit_stb;
   logic       bit_in;
   logic       desync;
   logic [7:0] byte_out;
   logic       byte_stb;
   logic       frame_start;
   logic       frame_end;
   logic       crc_ok;
   logic       len_err;
   logic       abort;
   logic       busy;

   modport master (
      output bit_stb, bit_in, desync,
      input  byte_out, byte_stb, frame_start, frame_end, crc_ok, len_err, abort, busy
   );

   modport slave (
      input  bit_stb, bit_in, desync,
      output byte_out, byte_stb, frame_start, frame_end, crc_ok, len_err, abort, busy
   );
endinterface

// File: rtl/felica_deframer.sv
// FeliCa / NFC-F deframer: hunts preamble + SYNC 0xB24D, emits LEN and payload bytes,
// checks the trailing CRC-16/CCITT and reports frame end, length errors and aborts.
module felica_deframer #(
   parameter int unsigned PRE_MIN = 16
) (
   input logic              adc_clk,
   input logic              rst,
   felica_deframer_if.slave bus
);
   typedef enum logic [2:0] {StHunt, StSync, StLen, StData, StCrc} state_e;

   localparam logic [5:0]  PreMin   = 6'(PRE_MIN);
   localparam logic [15:0] SyncWord = 16'hB24D;
   localparam logic [15:0] CrcPoly  = 16'h1021;

   state_e      state_q;
   logic [5:0]  zero_run_q;
   logic [15:0] shift_q;
   logic [3:0]  bit_cnt_q;
   logic [7:0]  remaining_q;
   logic [15:0] crc_q;
   logic [7:0]  byte_q;
   logic        byte_stb_q, frame_start_q, frame_end_q, crc_ok_q, len_err_q, abort_q, busy_q;

   logic [15:0] shift_d;
   logic [15:0] crc_d;
   logic [5:0]  zero_run_d;

   always_comb begin
      shift_d = {shift_q[14:0], bus.bit_in};
      crc_d   = {crc_q[14:0], 1'b0} ^ ((crc_q[15] ^ bus.bit_in) ? CrcPoly : 16'h0000);
      if (bus.bit_in) begin
         zero_run_d = '0;
      end else if (zero_run_q == 6'd63) begin
         zero_run_d = zero_run_q;
      end else begin
         zero_run_d = zero_run_q + 6'd1;
      end
   end

   always_ff @(posedge adc_clk or posedge rst) begin
      if (rst) begin
         state_q       <= StHunt;
         zero_run_q    <= '0;
         shift_q       <= '0;
         bit_cnt_q     <= '0;
         remaining_q   <= '0;
         crc_q         <= '0;
         byte_q        <= '0;
         byte_stb_q    <= 1'b0;
         frame_start_q <= 1'b0;
         frame_end_q   <= 1'b0;
         crc_ok_q      <= 1'b0;
         len_err_q     <= 1'b0;
         abort_q       <= 1'b0;
         busy_q        <= 1'b0;
      end else begin
         byte_stb_q    <= 1'b0;
         frame_start_q <= 1'b0;
         frame_end_q   <= 1'b0;
         len_err_q     <= 1'b0;
         abort_q       <= 1'b0;
         if (bus.desync && state_q != StHunt) begin
            // Loss of carrier beats a coincident bit; only a committed frame reports abort.
            abort_q <= busy_q;
            busy_q  <= 1'b0;
            state_q <= StHunt;
         end else if (bus.bit_stb) begin
            zero_run_q <= zero_run_d;
            shift_q    <= shift_d;
            case (state_q)
               StHunt: begin
                  if (bus.bit_in && zero_run_q >= PreMin) begin
                     shift_q   <= 16'h0001;
                     bit_cnt_q <= 4'd1;
                     state_q   <= StSync;
                  end
               end
               StSync: begin
                  bit_cnt_q <= bit_cnt_q + 4'd1;
                  if (bit_cnt_q == 4'd15) begin
                     bit_cnt_q <= '0;
                     if (shift_d == SyncWord) begin
                        frame_start_q <= 1'b1;
                        busy_q        <= 1'b1;
                        crc_ok_q      <= 1'b0;
                        crc_q         <= '0;
                        state_q       <= StLen;
                     end else begin
                        state_q <= StHunt;
                     end
                  end
               end
               StLen: begin
                  crc_q     <= crc_d;
                  bit_cnt_q <= bit_cnt_q + 4'd1;
                  if (bit_cnt_q == 4'd7) begin
                     bit_cnt_q <= '0;
                     if (shift_d[7:0] == 8'h00) begin
                        len_err_q <= 1'b1;
                        busy_q    <= 1'b0;
                        state_q   <= StHunt;
                     end else begin
                        byte_q      <= shift_d[7:0];
                        byte_stb_q  <= 1'b1;
                        remaining_q <= shift_d[7:0] - 8'd1;
                        state_q     <= (shift_d[7:0] == 8'h01) ? StCrc : StData;
                     end
                  end
               end
               StData: begin
                  crc_q     <= crc_d;
                  bit_cnt_q <= bit_cnt_q + 4'd1;
                  if (bit_cnt_q == 4'd7) begin
                     bit_cnt_q   <= '0;
                     byte_q      <= shift_d[7:0];
                     byte_stb_q  <= 1'b1;
                     remaining_q <= remaining_q - 8'd1;
                     if (remaining_q == 8'd1) begin
                        state_q <= StCrc;
                     end
                  end
               end
               StCrc: begin
                  bit_cnt_q <= bit_cnt_q + 4'd1;
                  if (bit_cnt_q == 4'd15) begin
                     // A new preamble must be counted from scratch after each frame.
                     zero_run_q  <= '0;
                     bit_cnt_q   <= '0;
                     crc_ok_q    <= (shift_d == crc_q);
                     frame_end_q <= 1'b1;
                     busy_q      <= 1'b0;
                     state_q     <= StHunt;
                  end
               end
               default: state_q <= StHunt;
            endcase
         end
      end
   end

   assign bus.byte_out    = byte_q;
   assign bus.byte_stb    = byte_stb_q;
   assign bus.frame_start = frame_start_q;
   assign bus.frame_end   = frame_end_q;
   assign bus.crc_ok      = crc_ok_q;
   assign bus.len_err     = len_err_q;
   assign bus.abort       = abort_q;
   assign bus.busy        = busy_q;
endmodule

// File: tb/tb_felica_deframer.sv
// Self-checking bench for felica_deframer: vector table, directed desync/reset sequences
// and random bit streams scored against a stream-level frame parser.
module tb_felica_deframer;
   localparam int unsigned PreMin = 16;

   logic adc_clk = 1'b0;
   logic rst;
   felica_deframer_if bus();

   felica_deframer #(.PRE_MIN(PreMin)) dut (
      .adc_clk(adc_clk),
      .rst    (rst),
      .bus    (bus)
   );

   always #5 adc_clk = ~adc_clk;

   int total = 0;
   int bad   = 0;

   int         n_start, n_end, n_lenerr, n_abort, n_busy_bits;
   logic [7:0] got_bytes[$];
   bit         got_crc[$];

   bit         stim[$];
   logic [7:0] frame_bytes[$];
   logic [7:0] exp_bytes[$];
   bit         exp_crc[$];
   int         exp_starts, exp_lenerrs;

   typedef struct {
      int          pre;
      logic [15:0] sync;
      logic [7:0]  len;
      bit          crc_good;
      int          exp_start;
      int          exp_nbytes;
      int          exp_end;
      bit          exp_crc_ok;
      int          exp_lenerr;
      int          exp_busy;
   } vec_t;

   vec_t vecs[9];

   always @(negedge adc_clk) begin
      if (bus.frame_start) n_start++;
      if (bus.frame_end) begin
         n_end++;
         got_crc.push_back(bus.crc_ok);
      end
      if (bus.byte_stb) got_bytes.push_back(bus.byte_out);
      if (bus.len_err) n_lenerr++;
      if (bus.abort) n_abort++;
      if (bus.bit_stb && bus.busy) n_busy_bits++;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic check_idle(input string name);
      check(name, {bus.byte_out, bus.byte_stb, bus.frame_start, bus.frame_end, bus.crc_ok,
                   bus.len_err, bus.abort, bus.busy}, 32'h0);
   endtask

   task automatic clear_mon();
      n_start = 0; n_end = 0; n_lenerr = 0; n_abort = 0; n_busy_bits = 0;
      got_bytes.delete();
      got_crc.delete();
   endtask

   function automatic logic [15:0] crc_byte(input logic [15:0] c_in, input logic [7:0] d);
      logic [15:0] c;
      c = c_in ^ {d, 8'h00};
      for (int b = 0; b < 8; b++) c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
      return c;
   endfunction

   function automatic int next_run(input int run, input bit b);
      if (b) return 0;
      return (run < 63) ? run + 1 : 63;
   endfunction

   task automatic push_bits(input logic [15:0] v, input int n);
      for (int k = n - 1; k >= 0; k--) stim.push_back(v[k]);
   endtask

   // Separator 1, preamble, sync, LEN, payload, CRC (payload/CRC omitted when LEN is 0).
   task automatic build_frame(input int pre, input logic [15:0] sync, input logic [7:0] len,
                              input bit good, input int seed, input bit rnd);
      logic [15:0] c;
      logic [7:0]  p;
      frame_bytes.delete();
      stim.push_back(1'b1);
      for (int k = 0; k < pre; k++) stim.push_back(1'b0);
      push_bits(sync, 16);
      push_bits({8'h00, len}, 8);
      if (len != 8'h00) begin
         frame_bytes.push_back(len);
         c = crc_byte(16'h0000, len);
         for (int k = 1; k < int'(len); k++) begin
            p = rnd ? 8'($urandom) : 8'(seed * 29 + k * 13 + 7);
            frame_bytes.push_back(p);
            push_bits({8'h00, p}, 8);
            c = crc_byte(c, p);
         end
         push_bits(good ? c : (c ^ 16'h0001), 16);
      end
   endtask

   task automatic send_bit(input bit b);
      bus.bit_in  = b;
      bus.bit_stb = 1'b1;
      @(posedge adc_clk); #1;
      bus.bit_stb = 1'b0;
      repeat (15) @(posedge adc_clk);
      #1;
   endtask

   task automatic drive_stim();
      foreach (stim[k]) send_bit(stim[k]);
      stim.delete();
      repeat (4) @(posedge adc_clk);
      #1;
   endtask

   task automatic read_bits(inout int i, inout int run, input int n, output logic [15:0] v);
      v = '0;
      for (int k = 0; k < n; k++) begin
         v   = {v[14:0], stim[i]};
         run = next_run(run, stim[i]);
         i++;
      end
   endtask

   // Scan the bit stream as a whole: find preamble+SYNC, then parse LEN/payload/CRC.
   task automatic model_stim();
      int          i, run, len;
      logic [15:0] w, c;
      i = 0; run = 0;
      exp_bytes.delete(); exp_crc.delete();
      exp_starts = 0; exp_lenerrs = 0;
      while (i < stim.size()) begin
         if (stim[i] && run >= int'(PreMin) && i + 16 <= stim.size()) begin
            read_bits(i, run, 16, w);
            if (w == 16'hB24D) begin
               exp_starts++;
               if (i + 8 > stim.size()) break;
               read_bits(i, run, 8, w);
               len = int'(w[7:0]);
               if (len == 0) begin
                  exp_lenerrs++;
               end else begin
                  exp_bytes.push_back(w[7:0]);
                  c = crc_byte(16'h0000, w[7:0]);
                  if (i + 8 * (len - 1) + 16 > stim.size()) break;
                  for (int k = 1; k < len; k++) begin
                     read_bits(i, run, 8, w);
                     exp_bytes.push_back(w[7:0]);
                     c = crc_byte(c, w[7:0]);
                  end
                  read_bits(i, run, 16, w);
                  exp_crc.push_back(w == c);
                  run = 0;
               end
            end
         end else begin
            run = next_run(run, stim[i]);
            i++;
         end
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: time limit reached before end of test");
      $fatal(1, "time limit");
   end

   initial begin
      vecs[0] = '{48, 16'hB24D, 8'h01, 1'b1, 1, 1, 1, 1'b1, 0, 24};
      vecs[1] = '{48, 16'hB24D, 8'h01, 1'b0, 1, 1, 1, 1'b0, 0, 24};
      vecs[2] = '{ 8, 16'hB24D, 8'h01, 1'b1, 0, 0, 0, 1'b0, 0,  0};
      vecs[3] = '{20, 16'hB24D, 8'h01, 1'b1, 1, 1, 1, 1'b1, 0, 24};
      vecs[4] = '{48, 16'hB24D, 8'h00, 1'b1, 1, 0, 0, 1'b0, 1,  8};
      vecs[5] = '{48, 16'hB24C, 8'h01, 1'b1, 0, 0, 0, 1'b0, 0,  0};
      vecs[6] = '{16, 16'hB24D, 8'h04, 1'b1, 1, 4, 1, 1'b1, 0, 48};
      vecs[7] = '{15, 16'hB24D, 8'h01, 1'b1, 0, 0, 0, 1'b0, 0,  0};
      vecs[8] = '{63, 16'hB24D, 8'h03, 1'b0, 1, 3, 1, 1'b0, 0, 40};

      rst = 1'b1;
      bus.bit_stb = 1'b0; bus.bit_in = 1'b0; bus.desync = 1'b0;
      clear_mon();
      repeat (3) @(posedge adc_clk);
      #1;
      check_idle("reset_outputs");
      rst = 1'b0;
      repeat (2) @(posedge adc_clk);
      #1;

      // desync while hunting is ignored
      bus.desync = 1'b1;
      @(posedge adc_clk); #1;
      bus.desync = 1'b0;
      repeat (3) @(posedge adc_clk);
      #1;
      check("hunt_desync_abort", n_abort, 0);

      for (int r = 0; r < 9; r++) begin
         clear_mon();
         build_frame(vecs[r].pre, vecs[r].sync, vecs[r].len, vecs[r].crc_good, r, 1'b0);
         drive_stim();
         check($sformatf("row%0d_start", r), n_start, vecs[r].exp_start);
         check($sformatf("row%0d_nbytes", r), got_bytes.size(), vecs[r].exp_nbytes);
         check($sformatf("row%0d_end", r), n_end, vecs[r].exp_end);
         check($sformatf("row%0d_lenerr", r), n_lenerr, vecs[r].exp_lenerr);
         check($sformatf("row%0d_busy_bits", r), n_busy_bits, vecs[r].exp_busy);
         check($sformatf("row%0d_busy_low", r), bus.busy, 0);
         for (int k = 0; k < got_bytes.size() && k < frame_bytes.size(); k++)
            check($sformatf("row%0d_byte%0d", r, k), got_bytes[k], frame_bytes[k]);
         if (got_crc.size() > 0)
            check($sformatf("row%0d_crc_ok", r), got_crc[0], vecs[r].exp_crc_ok);
      end

      // desync four bits into LEN
      clear_mon();
      stim.push_back(1'b1);
      for (int k = 0; k < 48; k++) stim.push_back(1'b0);
      push_bits(16'hB24D, 16);
      push_bits(16'h0000, 4);
      drive_stim();
      check("dsy_busy_before", bus.busy, 1);
      bus.desync = 1'b1;
      @(posedge adc_clk); #1;
      bus.desync = 1'b0;
      check("dsy_abort_pulse", bus.abort, 1);
      repeat (3) @(posedge adc_clk);
      #1;
      check("dsy_abort_cnt", n_abort, 1);
      check("dsy_busy_after", bus.busy, 0);
      check("dsy_no_bytes", got_bytes.size(), 0);
      clear_mon();
      build_frame(48, 16'hB24D, 8'h01, 1'b1, 0, 1'b0);
      drive_stim();
      check("dsy_next_end", n_end, 1);
      check("dsy_next_crc", (got_crc.size() == 1) ? got_crc[0] : 1'b0, 1);

      // asynchronous reset in the middle of DATA
      clear_mon();
      stim.push_back(1'b1);
      for (int k = 0; k < 48; k++) stim.push_back(1'b0);
      push_bits(16'hB24D, 16);
      push_bits(16'h0003, 8);
      push_bits(16'h000A, 4);
      drive_stim();
      check("rst_busy_before", bus.busy, 1);
      #2 rst = 1'b1;
      #1;
      check_idle("rst_mid_data_outputs");
      repeat (2) @(posedge adc_clk);
      #1 rst = 1'b0;
      repeat (2) @(posedge adc_clk);
      #1;
      check("rst_no_abort", n_abort, 0);
      check("rst_no_end", n_end, 0);
      clear_mon();
      build_frame(48, 16'hB24D, 8'h02, 1'b1, 5, 1'b0);
      drive_stim();
      check("rst_next_bytes", got_bytes.size(), 2);
      check("rst_next_end", n_end, 1);
      check("rst_next_crc", (got_crc.size() == 1) ? got_crc[0] : 1'b0, 1);

      // random stream against the stream-level parser
      clear_mon();
      for (int f = 0; f < 10; f++) begin
         logic [15:0] sw;
         sw = 16'hB24D;
         if ($urandom_range(0, 4) == 0) sw = sw ^ (16'h0001 << $urandom_range(0, 15));
         build_frame($urandom_range(12, 30), sw, 8'($urandom_range(0, 4)),
                     $urandom_range(0, 3) != 0, f, 1'b1);
      end
      model_stim();
      drive_stim();
      check("rnd_starts", n_start, exp_starts);
      check("rnd_lenerr", n_lenerr, exp_lenerrs);
      check("rnd_ends", n_end, exp_crc.size());
      check("rnd_nbytes", got_bytes.size(), exp_bytes.size());
      for (int k = 0; k < got_bytes.size() && k < exp_bytes.size(); k++)
         check($sformatf("rnd_byte%0d", k), got_bytes[k], exp_bytes[k]);
      for (int k = 0; k < got_crc.size() && k < exp_crc.size(); k++)
         check($sformatf("rnd_crc%0d", k), got_crc[k], exp_crc[k]);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
